flappy_game_ctrl: RTL and testbench

Frame-level game controller that sequences the bird physics block and the pipe obstacles once per video frame. Each frame it issues a step request to the bird FSM, scrolls and respawns two pipes, detects collisions, keeps the score and owns the Init/Play/Lost game state. It sits between the VGA/top level and the bird FSM, driving its Bird_Step and Bird_Hold inputs.

---
 rtl/flappy_game_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame game sequencer for the bird physics block and
// two scrolling pipes. Once per frame it requests a bird step, scrolls and
// respawns the pipes, keeps the score and decides on collisions.
//
// Ports:
//   Clk, Reset_n            system clock, async active-low reset
//   Start, Ack              level inputs: INIT->play, LOST->INIT
//   YBird, Bird_Done        bird top Y and step-complete pulse from bird FSM
//   Bird_Step, Bird_Hold    step request pulse / hold bird at start position
//   Pipe0_X/Pipe1_X         pipe left X
//   Pipe0_GapY/Pipe1_GapY   gap top Y
//   Score                   pipes passed, saturating at 255
//   Frame_Tick              one-cycle pulse per frame
//   q_Init, q_Play, q_Lost  one-hot game state
//
// Build option: FLAPPY_SPEEDUP_EN adds 1 px/frame of scroll per 8 points,
// capped at +3. Without it the scroll is the constant SCROLL.
//
// state  | meaning
// INIT   | pipes held at start positions, wait for Start
// WAIT   | playing, wait for frame tick (or queued tick)
// STEP   | bird step requested, wait for Bird_Done
// SCROLL | move pipes, respawn, count passed pipes
// CHECK  | ground / ceiling / pipe collision test
// LOST   | everything frozen, wait for Ack
module flappy_game_ctrl #(
  parameter int FRAME_DIV    = 1666667,
  parameter int SCREEN_W     = 640,
  parameter int GROUND_Y     = 464,
  parameter int BIRD_X       = 100,
  parameter int BIRD_SIZE    = 16,
  parameter int PIPE_W       = 40,
  parameter int GAP_H        = 120,
  parameter int PIPE_SPACING = 320,
  parameter int SCROLL       = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Ack,
  input  logic [9:0] YBird,
  input  logic       Bird_Done,
  output logic       Bird_Step,
  output logic       Bird_Hold,
  output logic [9:0] Pipe0_X,
  output logic [9:0] Pipe1_X,
  output logic [9:0] Pipe0_GapY,
  output logic [9:0] Pipe1_GapY,
  output logic [7:0] Score,
  output logic       Frame_Tick,
  output logic       q_Init,
  output logic       q_Play,
  output logic       q_Lost
);

  localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam logic [9:0]  X0_RST = 10'(SCREEN_W);
  localparam logic [9:0]  X1_RST = 10'(SCREEN_W + PIPE_SPACING);
  localparam logic [9:0]  GY_RST = 10'd176;
  localparam logic [10:0] BX  = 11'(BIRD_X);
  localparam logic [10:0] BS  = 11'(BIRD_SIZE);
  localparam logic [10:0] PW  = 11'(PIPE_W);
  localparam logic [10:0] GH  = 11'(GAP_H);
  localparam logic [10:0] GY  = 11'(GROUND_Y);
  localparam logic [10:0] SP  = 11'(PIPE_SPACING);
  localparam logic [10:0] SC  = 11'(SCROLL);

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_STEP, S_SCROLL, S_CHECK, S_LOST} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       lfsr_q;
  logic             pend_q, pend_d;
  logic             step_q, step_d;
  logic [9:0]       px0_q, px0_d, px1_q, px1_d;
  logic [9:0]       gy0_q, gy0_d, gy1_q, gy1_d;
  logic [7:0]       score_q, score_d;
  logic             tick;

  assign tick = (cnt_q == CNT_W'(FRAME_DIV - 1));

  // Frame counter and LFSR run in every state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= '0;
      lfsr_q <= 8'hA5;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Scroll amount for this frame.
  logic [10:0] s_w;
`ifdef FLAPPY_SPEEDUP_EN
  logic [10:0] boost;
  always_comb begin
    boost = (score_q[7:3] > 5'd3) ? 11'd3 : {6'b0, score_q[7:3]};
  end
  assign s_w = SC + boost;
`else
  assign s_w = SC;
`endif

  // Scroll datapath, all in 11 bits so nothing wraps.
  logic [10:0] x0, x1, nx0, nx1;
  logic        resp0, resp1, pass0, pass1;
  logic [1:0]  inc;
  logic [8:0]  score_sum;

  assign x0    = {1'b0, px0_q};
  assign x1    = {1'b0, px1_q};
  assign nx0   = x0 - s_w;
  assign nx1   = x1 - s_w;
  assign resp0 = (x0 <= s_w);
  assign resp1 = (x1 <= s_w);
  // A pipe is passed when its right edge moves from >= BIRD_X to < BIRD_X.
  assign pass0 = !resp0 && (x0 + PW >= BX) && (nx0 + PW < BX);
  assign pass1 = !resp1 && (x1 + PW >= BX) && (nx1 + PW < BX);
  assign inc       = {1'b0, pass0} + {1'b0, pass1};
  assign score_sum = {1'b0, score_q} + {7'b0, inc};

  // Collision against post-scroll pipe positions.
  logic [10:0] yb;
  logic        ground, hit0, hit1;

  assign yb     = {1'b0, YBird};
  assign ground = (yb + BS >= GY) || (YBird == 10'd0);
  assign hit0   = (x0 < BX + BS) && (x0 + PW > BX) &&
                  ((yb < {1'b0, gy0_q}) || (yb + BS > {1'b0, gy0_q} + GH));
  assign hit1   = (x1 < BX + BS) && (x1 + PW > BX) &&
                  ((yb < {1'b0, gy1_q}) || (yb + BS > {1'b0, gy1_q} + GH));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_INIT;
      pend_q  <= 1'b0;
      step_q  <= 1'b0;
      px0_q   <= X0_RST;
      px1_q   <= X1_RST;
      gy0_q   <= GY_RST;
      gy1_q   <= GY_RST;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      step_q  <= step_d;
      px0_q   <= px0_d;
      px1_q   <= px1_d;
      gy0_q   <= gy0_d;
      gy1_q   <= gy1_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    step_d  = 1'b0;
    px0_d   = px0_q;
    px1_d   = px1_q;
    gy0_d   = gy0_q;
    gy1_d   = gy1_q;
    score_d = score_q;
    // Ticks that land while a frame is being processed queue (depth one).
    if (tick && (state_q == S_STEP || state_q == S_SCROLL || state_q == S_CHECK))
      pend_d = 1'b1;
    case (state_q)
      S_INIT: begin
        px0_d = X0_RST;
        px1_d = X1_RST;
        gy0_d = GY_RST;
        gy1_d = GY_RST;
        if (Start) begin
          score_d = 8'd0;
          pend_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick || pend_q) begin
          pend_d  = 1'b0;
          step_d  = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (Bird_Done) state_d = S_SCROLL;
      end
      S_SCROLL: begin
        if (resp0) begin
          px0_d = 10'(nx1 + SP);
          gy0_d = {2'b0, lfsr_q} + 10'd64;
        end else begin
          px0_d = nx0[9:0];
        end
        if (resp1) begin
          px1_d = 10'(nx0 + SP);
          gy1_d = {2'b0, lfsr_q} + 10'd64;
        end else begin
          px1_d = nx1[9:0];
        end
        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (ground || hit0 || hit1) ? S_LOST : S_WAIT;
      end
      S_LOST: begin
        if (Ack) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign Bird_Step  = step_q;
  assign Bird_Hold  = (state_q == S_INIT) || (state_q == S_LOST);
  assign Pipe0_X    = px0_q;
  assign Pipe1_X    = px1_q;
  assign Pipe0_GapY = gy0_q;
  assign Pipe1_GapY = gy1_q;
  assign Score      = score_q;
  assign Frame_Tick = tick;
  assign q_Init     = (state_q == S_INIT);
  assign q_Lost     = (state_q == S_LOST);
  assign q_Play     = !q_Init && !q_Lost;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;
  localparam int FD = 16;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic [9:0] YBird = 10'd200;
  logic       Bird_Done = 1'b0;
  logic       Bird_Step, Bird_Hold, Frame_Tick, q_Init, q_Play, q_Lost;
  logic [9:0] Pipe0_X, Pipe1_X, Pipe0_GapY, Pipe1_GapY;
  logic [7:0] Score;

  flappy_game_ctrl #(.FRAME_DIV(FD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .YBird(YBird),
    .Bird_Done(Bird_Done), .Bird_Step(Bird_Step), .Bird_Hold(Bird_Hold),
    .Pipe0_X(Pipe0_X), .Pipe1_X(Pipe1_X), .Pipe0_GapY(Pipe0_GapY),
    .Pipe1_GapY(Pipe1_GapY), .Score(Score), .Frame_Tick(Frame_Tick),
    .q_Init(q_Init), .q_Play(q_Play), .q_Lost(q_Lost)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Cycle index since reset release, and the free-running LFSR value for
  // that cycle, derived from the polynomial x^8+x^6+x^5+x^4+1.
  int         cyc;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc    <= 0;
      m_lfsr <= 8'hA5;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  // Game model.
  int m_x[2];
  int m_g[2];
  int m_score;
  int exp_step;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cur_s();
    int s;
    s = 2;
`ifdef FLAPPY_SPEEDUP_EN
    s = s + (((m_score / 8) > 3) ? 3 : (m_score / 8));
`endif
    return s;
  endfunction

  function automatic int next_tick_from(input int c);
    return c + (((FD - 1) - (c % FD)) + FD) % FD;
  endfunction

  task automatic model_reset_pipes();
    m_x[0] = 640;
    m_x[1] = 960;
    m_g[0] = 176;
    m_g[1] = 176;
  endtask

  task automatic model_scroll(input int lf);
    int s, inc;
    int nx[2];
    int newx[2];
    bit rs[2];
    s = cur_s();
    inc = 0;
    for (int i = 0; i < 2; i++) begin
      nx[i] = m_x[i] - s;
      rs[i] = (m_x[i] <= s);
    end
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        newx[i] = (nx[1 - i] + 320) % 1024;
        m_g[i]  = 64 + lf;
      end else begin
        newx[i] = nx[i];
        if (m_x[i] + 40 >= 100 && nx[i] + 40 < 100) inc++;
      end
    end
    m_x[0] = newx[0];
    m_x[1] = newx[1];
    m_score = (m_score + inc > 255) ? 255 : m_score + inc;
  endtask

  function automatic bit model_lost(input int yb);
    bit l;
    l = (yb + 16 >= 464) || (yb == 0);
    for (int i = 0; i < 2; i++)
      if (m_x[i] < 116 && m_x[i] + 40 > 100 && (yb < m_g[i] || yb + 16 > m_g[i] + 120))
        l = 1'b1;
    return l;
  endfunction

  // YBird inside the gap of the next pipe the bird has to fly through.
  function automatic int pick_yb();
    int best;
    best = -1;
    for (int i = 0; i < 2; i++)
      if (m_x[i] - cur_s() + 40 > 100 && (best < 0 || m_x[i] < m_x[best])) best = i;
    if (best < 0) return 200;
    return m_g[best] + $urandom_range(1, 100);
  endfunction

  task automatic nclk();
    @(negedge Clk);
    chk("frame_tick", int'(Frame_Tick), int'((cyc % FD) == FD - 1));
  endtask

  task automatic chk_pipes(input string tag);
    chk({tag, "_p0x"}, int'(Pipe0_X), m_x[0]);
    chk({tag, "_p1x"}, int'(Pipe1_X), m_x[1]);
    chk({tag, "_p0g"}, int'(Pipe0_GapY), m_g[0]);
    chk({tag, "_p1g"}, int'(Pipe1_GapY), m_g[1]);
    chk({tag, "_score"}, int'(Score), m_score);
  endtask

  task automatic start_game();
    int cs;
    chk("pre_start_init", int'(q_Init), 1);
    Start = 1'b1;
    cs = cyc;
    nclk();
    Start = 1'b0;
    m_score = 0;
    chk("start_play", int'(q_Play), 1);
    chk("start_score", int'(Score), 0);
    chk("start_hold", int'(Bird_Hold), 0);
    exp_step = next_tick_from(cs + 1) + 1;
  endtask

  task automatic lost_to_init();
    repeat (10) nclk();
    chk_pipes("frozen");
    chk("frozen_lost", int'(q_Lost), 1);
    Ack = 1'b1;
    nclk();
    Ack = 1'b0;
    chk("ack_init", int'(q_Init), 1);
    chk("ack_score_kept", int'(Score), m_score);
    nclk();
    model_reset_pipes();
    chk_pipes("init_reload");
  endtask

  task automatic wait_step();
    while (cyc < exp_step) begin
      chk("no_early_step", int'(Bird_Step), 0);
      Start = 1'($urandom_range(0, 1));
      Ack   = 1'($urandom_range(0, 1));
      nclk();
    end
    Start = 1'b0;
    Ack   = 1'b0;
    chk("bird_step", int'(Bird_Step), 1);
  endtask

  task automatic run_frame(input int yb, input int d, output bit lost);
    int s_cyc, e_cyc;
    YBird = 10'(yb);
    wait_step();
    chk("step_play", int'(q_Play), 1);
    s_cyc = cyc;
    repeat (d) nclk();
    Bird_Done = 1'b1;
    nclk();
    Bird_Done = 1'b0;
    model_scroll(int'(m_lfsr));
    nclk();
    e_cyc = cyc;
    chk("step_pulse_end", int'(Bird_Step), 0);
    chk_pipes("scroll");
    lost = model_lost(yb);
    nclk();
    chk("lost_state", int'(q_Lost), int'(lost));
    chk("play_state", int'(q_Play), int'(!lost));
    chk("hold", int'(Bird_Hold), int'(lost));
    if (next_tick_from(s_cyc) <= e_cyc) exp_step = e_cyc + 2;
    else exp_step = next_tick_from(e_cyc + 1) + 1;
  endtask

  typedef struct {
    int yb;
    bit lost;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit l;
    int guard;
    tbl[0] = '{yb: 200, lost: 1'b0};
    tbl[1] = '{yb: 447, lost: 1'b0};
    tbl[2] = '{yb: 448, lost: 1'b1};
    tbl[3] = '{yb: 1,   lost: 1'b0};
    tbl[4] = '{yb: 0,   lost: 1'b1};
    tbl[5] = '{yb: 450, lost: 1'b1};

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset_pipes();
    m_score = 0;
    chk("rst_init", int'(q_Init), 1);
    chk("rst_play", int'(q_Play), 0);
    chk("rst_lost", int'(q_Lost), 0);
    chk("rst_hold", int'(Bird_Hold), 1);
    chk("rst_step", int'(Bird_Step), 0);
    chk("rst_tick", int'(Frame_Tick), 0);
    chk_pipes("rst");
    repeat (20) nclk();
    chk("init_still", int'(q_Init), 1);

    // Ground / ceiling boundary vectors, far from any pipe.
    start_game();
    for (int k = 0; k < 6; k++) begin
      run_frame(tbl[k].yb, $urandom_range(0, 6), l);
      chk("tbl_lost", int'(q_Lost), int'(tbl[k].lost));
      if (q_Lost) begin
        lost_to_init();
        start_game();
      end
    end

    // Long run: pass pipes, respawns, queued tick after a slow bird step.
    for (int f = 0; f < 500; f++) begin
      int yb, d;
      yb = pick_yb();
      if (m_x[0] - cur_s() == 100 && m_g[0] == 176) yb = 200;
      d = (f == 40 || f == 300) ? 40 : $urandom_range(0, 6);
      run_frame(yb, d, l);
      if (d == 40) chk("one_queued_tick", exp_step - cyc, 1);
      if (q_Lost) break;
    end
    chk("score_after_run", int'(Score >= 8'd2), 1);
    run_frame(0, 1, l);
    chk("ceiling_lost", int'(q_Lost), 1);
    lost_to_init();
    start_game();

    // Bird overlapping pipe0 at X=100 and above the gap.
    guard = 0;
    l = 1'b0;
    while (!l && guard < 400) begin
      int yb;
      yb = (m_x[0] - cur_s() == 100) ? 150 : pick_yb();
      run_frame(yb, $urandom_range(0, 6), l);
      guard++;
    end
    chk("pipe_hit_x", m_x[0], 100);
    chk("pipe_hit_lost", int'(q_Lost), 1);
    lost_to_init();
    start_game();

    // Reset in the middle of a frame.
    wait_step();
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_step", int'(Bird_Step), 0);
    chk("mid_rst_init", int'(q_Init), 1);
    chk("mid_rst_p0x", int'(Pipe0_X), 640);
    chk("mid_rst_score", int'(Score), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
